// File: rtl/uart_mmio_pkg.sv
// Shared register map and STATUS bit layout for the UART MMIO bridge.
package uart_mmio_pkg;

  localparam logic [3:0] ADDR_STATUS = 4'h0;
  localparam logic [3:0] ADDR_RXDATA = 4'h4;
  localparam logic [3:0] ADDR_TXDATA = 4'h8;

  localparam int STAT_TX_READY = 0;
  localparam int STAT_RX_AVAIL = 1;
  localparam int STAT_OVERRUN  = 2;

  typedef enum logic [1:0] {
    REG_STATUS,
    REG_RXDATA,
    REG_TXDATA,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [3:0] addr);
    case (addr)
      ADDR_STATUS: return REG_STATUS;
      ADDR_RXDATA: return REG_RXDATA;
      ADDR_TXDATA: return REG_TXDATA;
      default:     return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// CPU access strobes plus the TX/RX ready/valid byte streams of the bridge.
interface uart_mmio_if;
  logic [3:0]  Addr;
  logic        RdEn;
  logic        WrEn;
  logic [7:0]  WrData;
  logic [31:0] RdData;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;

  modport slave (
    input  Addr, RdEn, WrEn, WrData, TxReady, RxData, RxValid,
    output RdData, TxData, TxValid, RxReady
  );

  modport master (
    output Addr, RdEn, WrEn, WrData, TxReady, RxData, RxValid,
    input  RdData, TxData, TxValid, RxReady
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// RX byte FIFO: ready/valid push, pop strobe (ignored when empty), head visible combinationally.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_vld_i,
  input  logic [7:0] push_dat_i,
  output logic       push_rdy_o,
  input  logic       pop_i,
  output logic [7:0] head_dat_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_fire, pop_fire;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == FULL_CNT);
  assign push_rdy_o = !full_o;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign push_fire  = push_vld_i && push_rdy_o;
  assign pop_fire   = pop_i && !empty_o;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_fire && !pop_fire)      count_d = count_q + 1'b1;
    else if (pop_fire && !push_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_fire && !rst_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// CPU-visible UART bridge: one-byte TX holding register, RX FIFO, registered read data.
// Define UART_MMIO_OVERRUN_EN to get the sticky RX overrun flag in STATUS bit 2.
module uart_mmio_bridge
  import uart_mmio_pkg::*;
#(
  parameter int RX_DEPTH = 8
) (
  input  logic      Clock,
  input  logic      Reset,
  uart_mmio_if.slave bus
);

  reg_sel_e    sel;
  logic        tx_full_q, tx_full_d;
  logic [7:0]  tx_dat_q, tx_dat_d;
  logic [31:0] rd_dat_q, rd_dat_d;
  logic        tx_drain, tx_wr, rx_pop, status_rd;
  logic        fifo_empty, fifo_full;
  logic [7:0]  fifo_head;
  logic        overrun;

  assign sel       = decode_addr(bus.Addr);
  assign tx_drain  = tx_full_q && bus.TxReady;
  assign tx_wr     = bus.WrEn && (sel == REG_TXDATA);
  assign rx_pop    = bus.RdEn && (sel == REG_RXDATA);
  assign status_rd = bus.RdEn && (sel == REG_STATUS);

  uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .push_vld_i (bus.RxValid),
    .push_dat_i (bus.RxData),
    .push_rdy_o (bus.RxReady),
    .pop_i      (rx_pop),
    .head_dat_o (fifo_head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

`ifdef UART_MMIO_OVERRUN_EN
  logic ovr_q, ovr_d;
  // A new overrun in the same cycle as the clearing read must not be lost.
  always_comb begin
    ovr_d = ovr_q;
    if (status_rd)                 ovr_d = 1'b0;
    if (bus.RxValid && fifo_full)  ovr_d = 1'b1;
  end
  always_ff @(posedge Clock) begin
    if (Reset) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end
  assign overrun = ovr_q;
`else
  assign overrun = 1'b0;
`endif

  always_comb begin
    tx_full_d = tx_full_q;
    tx_dat_d  = tx_dat_q;
    if (tx_wr && (!tx_full_q || tx_drain)) begin
      tx_full_d = 1'b1;
      tx_dat_d  = bus.WrData;
    end else if (tx_drain) begin
      tx_full_d = 1'b0;
    end
  end

  always_comb begin
    rd_dat_d = '0;
    if (status_rd) begin
      rd_dat_d[STAT_TX_READY] = !tx_full_q;
      rd_dat_d[STAT_RX_AVAIL] = !fifo_empty;
      rd_dat_d[STAT_OVERRUN]  = overrun;
    end else if (rx_pop && !fifo_empty) begin
      rd_dat_d = {24'b0, fifo_head};
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tx_full_q <= 1'b0;
      tx_dat_q  <= '0;
      rd_dat_q  <= '0;
    end else begin
      tx_full_q <= tx_full_d;
      tx_dat_q  <= tx_dat_d;
      rd_dat_q  <= rd_dat_d;
    end
  end

  assign bus.TxValid = tx_full_q;
  assign bus.TxData  = tx_dat_q;
  assign bus.RdData  = rd_dat_q;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Bench for uart_mmio_bridge: directed register scenarios, then random traffic against a queue model.
module tb_uart_mmio_bridge;

  localparam int DEPTH = 8;
`ifdef UART_MMIO_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  uart_mmio_if bus();

  uart_mmio_bridge #(.RX_DEPTH(DEPTH)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [7:0]  q[$];
  bit          m_txf;
  logic [7:0]  m_txd;
  logic [31:0] m_rd;
  bit          m_ovr;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour, evaluated on each rising edge from the inputs in force that cycle.
  task automatic model_tick();
    int n;
    bit drain;
    logic [31:0] rd;
    if (rst) begin
      q.delete();
      m_txf = 1'b0;
      m_txd = 8'h00;
      m_rd  = 32'h0;
      m_ovr = 1'b0;
      return;
    end
    n  = q.size();
    rd = 32'h0;
    if (bus.RdEn && bus.Addr == 4'h0) rd = {29'b0, m_ovr, (n != 0), !m_txf};
    if (bus.RdEn && bus.Addr == 4'h4 && n > 0) rd = {24'b0, q[0]};
    if (OVR_EN) begin
      if (bus.RdEn && bus.Addr == 4'h0) m_ovr = 1'b0;
      if (bus.RxValid && n == DEPTH)    m_ovr = 1'b1;
    end
    if (bus.RdEn && bus.Addr == 4'h4 && n > 0) void'(q.pop_front());
    if (bus.RxValid && n < DEPTH) q.push_back(bus.RxData);
    drain = m_txf && bus.TxReady;
    if (bus.WrEn && bus.Addr == 4'h8 && (!m_txf || drain)) begin
      m_txf = 1'b1;
      m_txd = bus.WrData;
    end else if (drain) begin
      m_txf = 1'b0;
    end
    m_rd = rd;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("TxValid", {31'b0, bus.TxValid}, {31'b0, m_txf});
      cmp("TxData",  {24'b0, bus.TxData},  {24'b0, m_txd});
      cmp("RxReady", {31'b0, bus.RxReady}, {31'b0, (q.size() < DEPTH)});
      cmp("RdData",  bus.RdData, m_rd);
    end
  end

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_inputs();
    bus.RdEn = 1'b0; bus.WrEn = 1'b0; bus.RxValid = 1'b0;
    bus.Addr = 4'h0; bus.WrData = 8'h00; bus.RxData = 8'h00;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    bus.RdEn = 1'b1; bus.Addr = a;
    step();
    bus.RdEn = 1'b0;
    d = bus.RdData;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] v);
    bus.WrEn = 1'b1; bus.Addr = a; bus.WrData = v;
    step();
    bus.WrEn = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] v);
    bus.RxValid = 1'b1; bus.RxData = v;
    step();
    bus.RxValid = 1'b0;
  endtask

  logic [31:0] d;
  logic [3:0]  addr_tbl [5];

  initial begin
    idle_inputs();
    bus.TxReady = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    cmp("reset TxValid", {31'b0, bus.TxValid}, 32'h0);
    cmp("reset RxReady", {31'b0, bus.RxReady}, 32'h1);
    cmp("reset RdData", bus.RdData, 32'h0);

    // TX holding register: load, drain, drop-while-full.
    do_write(4'h8, 8'h7A);
    cmp("tx load valid", {31'b0, bus.TxValid}, 32'h1);
    cmp("tx load data", {24'b0, bus.TxData}, 32'h7A);
    do_read(4'h0, d); cmp("status tx full", d, 32'h0);
    bus.TxReady = 1'b1; step(); bus.TxReady = 1'b0;
    cmp("tx drained", {31'b0, bus.TxValid}, 32'h0);
    do_read(4'h0, d); cmp("status tx empty", d, 32'h1);
    do_write(4'h8, 8'h7A);
    do_write(4'h8, 8'h55);
    cmp("tx drop keeps data", {24'b0, bus.TxData}, 32'h7A);
    bus.TxReady = 1'b1; step(); bus.TxReady = 1'b0;

    // Basic RX path.
    do_push(8'h11); do_push(8'h22);
    do_read(4'h0, d); cmp("status rx avail", d, 32'h3);
    do_read(4'h4, d); cmp("rx pop 1", d, 32'h11);
    do_read(4'h4, d); cmp("rx pop 2", d, 32'h22);
    do_read(4'h4, d); cmp("rx pop empty", d, 32'h0);
    do_read(4'h0, d); cmp("status rx drained", d, 32'h1);

    // Fill to full across the pointer wrap, then overrun.
    for (int i = 1; i <= DEPTH; i++) do_push(8'(i));
    cmp("full RxReady", {31'b0, bus.RxReady}, 32'h0);
    do_push(8'h09);
    do_read(4'h0, d); cmp("status overrun", d, OVR_EN ? 32'h7 : 32'h3);
    do_read(4'h0, d); cmp("status overrun cleared", d, 32'h3);
    for (int i = 1; i <= DEPTH; i++) begin
      do_read(4'h4, d); cmp("rx wrap order", d, 32'(i));
    end

    // Simultaneous push and pop at count 3.
    do_push(8'hA1); do_push(8'hA2); do_push(8'hA3);
    bus.RxValid = 1'b1; bus.RxData = 8'hA4;
    do_read(4'h4, d);
    bus.RxValid = 1'b0;
    cmp("push+pop old head", d, 32'hA1);
    do_read(4'h4, d); cmp("push+pop next 1", d, 32'hA2);
    do_read(4'h4, d); cmp("push+pop next 2", d, 32'hA3);
    do_read(4'h4, d); cmp("push+pop next 3", d, 32'hA4);
    do_read(4'h4, d); cmp("push+pop empty", d, 32'h0);

    // Reset mid-operation with strobes active.
    for (int i = 0; i < 4; i++) do_push(8'hC0 + 8'(i));
    do_write(4'h8, 8'h3C);
    rst = 1'b1;
    bus.WrEn = 1'b1; bus.Addr = 4'h8; bus.WrData = 8'hEE;
    bus.RxValid = 1'b1; bus.RxData = 8'hEE;
    step();
    rst = 1'b0;
    idle_inputs();
    cmp("midreset TxValid", {31'b0, bus.TxValid}, 32'h0);
    cmp("midreset TxData", {24'b0, bus.TxData}, 32'h0);
    cmp("midreset RxReady", {31'b0, bus.RxReady}, 32'h1);
    cmp("midreset RdData", bus.RdData, 32'h0);
    do_read(4'h4, d); cmp("post-reset rx read", d, 32'h0);
    do_read(4'h0, d); cmp("post-reset status", d, 32'h1);

    // Random traffic, checked every cycle by the compare process.
    addr_tbl[0] = 4'h0; addr_tbl[1] = 4'h4; addr_tbl[2] = 4'h8; addr_tbl[3] = 4'hC; addr_tbl[4] = 4'h4;
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      bus.RdEn    = ($urandom_range(0, 9) < 4);
      bus.WrEn    = ($urandom_range(0, 9) < 3);
      bus.Addr    = ($urandom_range(0, 19) == 0) ? 4'($urandom) : addr_tbl[$urandom_range(0, 4)];
      bus.WrData  = 8'($urandom);
      bus.TxReady = ($urandom_range(0, 1) == 1);
      bus.RxValid = ($urandom_range(0, 9) < (c % 600 < 300 ? 7 : 3));
      bus.RxData  = 8'($urandom);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
